// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: resolves load-use, multi-cycle multiply and
// data-memory wait hazards by stalling, flushing or bubbling pipeline registers.
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  idRsAddr_i,
  input  logic [4:0]  idRtAddr_i,
  input  logic        exMemRead_i,
  input  logic [4:0]  exRdAddr_i,
  input  logic        idIsMul_i,
  input  logic        branchTaken_i,
  input  logic        memReq_i,
  input  logic        memAck_i,
  output logic        pcStall_o,
  output logic        ifidStall_o,
  output logic        idexStall_o,
  output logic        exmemStall_o,
  output logic        ifidFlush_o,
  output logic        idexFlush_o,
  output logic        exmemBubble_o,
  output logic        memwbBubble_o,
  output logic        mulStart_o,
  output logic [1:0]  state_o,
  output logic [15:0] stallCount_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MUL_BUSY = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  // The issue cycle itself counts toward the latency, so the counter starts two short.
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 2);

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_mulCnt;
  logic [3:0]  w_nextMulCnt;
  logic        r_retMul;
  logic        w_nextRetMul;
  logic        r_mulFirst;
  logic        w_nextMulFirst;
  logic [15:0] r_stallCount;
  logic        w_memStall;
  logic        w_loadUse;

  assign w_memStall = memReq_i && !memAck_i && (r_state != MEM_WAIT);
  assign w_loadUse  = exMemRead_i && (exRdAddr_i != 5'd0) &&
                      ((exRdAddr_i == idRsAddr_i) || (exRdAddr_i == idRtAddr_i));

  assign state_o      = r_state;
  assign stallCount_o = r_stallCount;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= RUN;
      r_mulCnt     <= 4'd0;
      r_retMul     <= 1'b0;
      r_mulFirst   <= 1'b0;
      r_stallCount <= 16'd0;
    end else begin
      r_state    <= w_nextState;
      r_mulCnt   <= w_nextMulCnt;
      r_retMul   <= w_nextRetMul;
      r_mulFirst <= w_nextMulFirst;
      if (pcStall_o && (r_stallCount != 16'hFFFF)) begin
        r_stallCount <= r_stallCount + 16'd1;
      end
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextMulCnt   = r_mulCnt;
    w_nextRetMul   = r_retMul;
    w_nextMulFirst = 1'b0;
    case (r_state)
      RUN: begin
        if (w_memStall) begin
          w_nextState  = MEM_WAIT;
          w_nextRetMul = 1'b0;
        end else if (!w_loadUse && idIsMul_i) begin
          w_nextState    = MUL_BUSY;
          w_nextMulCnt   = MUL_CNT_INIT;
          w_nextMulFirst = 1'b1;
        end
      end
      MUL_BUSY: begin
        if (w_memStall) begin
          w_nextState  = MEM_WAIT;
          w_nextRetMul = 1'b1;
        end else if (r_mulCnt == 4'd0) begin
          w_nextState = RUN;
        end else begin
          w_nextMulCnt = r_mulCnt - 4'd1;
        end
      end
      MEM_WAIT: begin
        if (memAck_i) begin
          w_nextState = r_retMul ? MUL_BUSY : RUN;
        end
      end
      default: w_nextState = RUN;
    endcase
  end

  always_comb begin
    pcStall_o     = 1'b0;
    ifidStall_o   = 1'b0;
    idexStall_o   = 1'b0;
    exmemStall_o  = 1'b0;
    ifidFlush_o   = 1'b0;
    idexFlush_o   = 1'b0;
    exmemBubble_o = 1'b0;
    memwbBubble_o = 1'b0;
    mulStart_o    = 1'b0;
    if (!rst_i) begin
      case (r_state)
        RUN: begin
          if (w_memStall) begin
            pcStall_o     = 1'b1;
            ifidStall_o   = 1'b1;
            idexStall_o   = 1'b1;
            exmemStall_o  = 1'b1;
            memwbBubble_o = 1'b1;
          end else if (w_loadUse) begin
            pcStall_o   = 1'b1;
            ifidStall_o = 1'b1;
            idexFlush_o = 1'b1;
          end else begin
            ifidFlush_o = branchTaken_i;
          end
        end
        MUL_BUSY: begin
          mulStart_o = r_mulFirst;
          if (w_memStall) begin
            pcStall_o     = 1'b1;
            ifidStall_o   = 1'b1;
            idexStall_o   = 1'b1;
            exmemStall_o  = 1'b1;
            memwbBubble_o = 1'b1;
          end else begin
            pcStall_o     = 1'b1;
            ifidStall_o   = 1'b1;
            idexStall_o   = 1'b1;
            exmemBubble_o = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!memAck_i) begin
            pcStall_o     = 1'b1;
            ifidStall_o   = 1'b1;
            idexStall_o   = 1'b1;
            exmemStall_o  = 1'b1;
            memwbBubble_o = 1'b1;
          end else if (r_retMul) begin
            // Resuming a multiply: hold the front end as if already back in MUL_BUSY.
            pcStall_o     = 1'b1;
            ifidStall_o   = 1'b1;
            idexStall_o   = 1'b1;
            exmemBubble_o = 1'b1;
          end
        end
        default: begin
          pcStall_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios then
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MUL_LAT = 4;

  // Expected-output vector bit order:
  // {pcStall, ifidStall, idexStall, exmemStall, ifidFlush, idexFlush, exmemBubble, memwbBubble, mulStart}
  localparam logic [8:0] OUT_FREEZE  = 9'b111100010;
  localparam logic [8:0] OUT_BUSY    = 9'b111000100;
  localparam logic [8:0] OUT_LOADUSE = 9'b110001000;
  localparam logic [8:0] OUT_FLUSH   = 9'b000010000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  idRsAddr_i;
  logic [4:0]  idRtAddr_i;
  logic        exMemRead_i;
  logic [4:0]  exRdAddr_i;
  logic        idIsMul_i;
  logic        branchTaken_i;
  logic        memReq_i;
  logic        memAck_i;
  logic        pcStall_o;
  logic        ifidStall_o;
  logic        idexStall_o;
  logic        exmemStall_o;
  logic        ifidFlush_o;
  logic        idexFlush_o;
  logic        exmemBubble_o;
  logic        memwbBubble_o;
  logic        mulStart_o;
  logic [1:0]  state_o;
  logic [15:0] stallCount_o;

  int checks = 0;
  int failures = 0;

  // Model: mode 0=run, 1=multiply busy, 2=memory wait; mLeft is the number of
  // un-stalled busy cycles the multiply still owes.
  int mMode;
  int mLeft;
  int mStalls;
  bit mResume;
  bit mFirst;

  int obsMulStart;
  int obsBusyProg;
  int obsPcStall;
  logic [8:0]  lastOut;
  logic [1:0]  lastState;
  logic [15:0] lastCount;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .idRsAddr_i    (idRsAddr_i),
    .idRtAddr_i    (idRtAddr_i),
    .exMemRead_i   (exMemRead_i),
    .exRdAddr_i    (exRdAddr_i),
    .idIsMul_i     (idIsMul_i),
    .branchTaken_i (branchTaken_i),
    .memReq_i      (memReq_i),
    .memAck_i      (memAck_i),
    .pcStall_o     (pcStall_o),
    .ifidStall_o   (ifidStall_o),
    .idexStall_o   (idexStall_o),
    .exmemStall_o  (exmemStall_o),
    .ifidFlush_o   (ifidFlush_o),
    .idexFlush_o   (idexFlush_o),
    .exmemBubble_o (exmemBubble_o),
    .memwbBubble_o (memwbBubble_o),
    .mulStart_o    (mulStart_o),
    .state_o       (state_o),
    .stallCount_o  (stallCount_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    mMode   = 0;
    mLeft   = 0;
    mStalls = 0;
    mResume = 1'b0;
    mFirst  = 1'b0;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic applyStimulus(input bit rst, input int rs, input int rt, input bit exRead,
                               input int exRd, input bit isMul, input bit br,
                               input bit req, input bit ack);
    bit         memStall;
    bit         loadUse;
    logic [8:0] expOut;
    logic [8:0] actOut;
    int         nMode;
    int         nLeft;
    bit         nResume;
    bit         nFirst;
    rst_i         = rst;
    idRsAddr_i    = 5'(rs);
    idRtAddr_i    = 5'(rt);
    exMemRead_i   = exRead;
    exRdAddr_i    = 5'(exRd);
    idIsMul_i     = isMul;
    branchTaken_i = br;
    memReq_i      = req;
    memAck_i      = ack;
    @(negedge clk_i);

    memStall = req && !ack && (mMode != 2);
    loadUse  = exRead && (exRd != 0) && ((exRd == rs) || (exRd == rt));
    expOut   = 9'd0;
    nMode    = mMode;
    nLeft    = mLeft;
    nResume  = mResume;
    nFirst   = 1'b0;
    if (!rst) begin
      if (mMode == 0) begin
        if (memStall) begin
          expOut  = OUT_FREEZE;
          nMode   = 2;
          nResume = 1'b0;
        end else if (loadUse) begin
          expOut = OUT_LOADUSE;
        end else begin
          if (isMul) begin
            nMode  = 1;
            nLeft  = MUL_LAT - 1;
            nFirst = 1'b1;
          end
          if (br) expOut = OUT_FLUSH;
        end
      end else if (mMode == 1) begin
        if (memStall) begin
          expOut  = OUT_FREEZE;
          nMode   = 2;
          nResume = 1'b1;
        end else begin
          expOut = OUT_BUSY;
          nLeft  = mLeft - 1;
          if (nLeft == 0) nMode = 0;
        end
        expOut[0] = mFirst;
      end else begin
        if (!ack) expOut = OUT_FREEZE;
        else if (mResume) begin
          expOut = OUT_BUSY;
          nMode  = 1;
        end else nMode = 0;
      end
    end

    actOut = {pcStall_o, ifidStall_o, idexStall_o, exmemStall_o, ifidFlush_o,
              idexFlush_o, exmemBubble_o, memwbBubble_o, mulStart_o};
    checkOutput("ctrl", 32'(actOut), 32'(expOut));
    checkOutput("state", 32'(state_o), 32'(mMode));
    checkOutput("stallCount", 32'(stallCount_o), 32'(mStalls));

    lastOut   = actOut;
    lastState = state_o;
    lastCount = stallCount_o;
    if (mulStart_o) obsMulStart++;
    if (pcStall_o) obsPcStall++;
    if ((state_o == 2'b01) && exmemBubble_o) obsBusyProg++;

    if (rst) begin
      modelReset();
    end else begin
      if (expOut[8] && (mStalls < 65535)) mStalls++;
      mMode   = nMode;
      mLeft   = nLeft;
      mResume = nResume;
      mFirst  = nFirst;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clearObs();
    obsMulStart = 0;
    obsBusyProg = 0;
    obsPcStall  = 0;
  endtask

  initial begin
    rst_i         = 1'b1;
    idRsAddr_i    = 5'd0;
    idRtAddr_i    = 5'd0;
    exMemRead_i   = 1'b0;
    exRdAddr_i    = 5'd0;
    idIsMul_i     = 1'b0;
    branchTaken_i = 1'b0;
    memReq_i      = 1'b0;
    memAck_i      = 1'b0;
    clearObs();
    @(posedge clk_i);
    #1;
    modelReset();

    // Reset state: held in reset, all outputs low and counters cleared.
    applyStimulus(1'b1, 3, 4, 1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("reset_out", 32'(lastOut), 32'd0);

    // Load-use on r5: one stall cycle, one count.
    applyStimulus(1'b0, 5, 0, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_out", 32'(lastOut), 32'(OUT_LOADUSE));
    checkOutput("lu_count", 32'(stallCount_o), 32'd1);
    idle();

    // Multiply: three busy cycles, a single start pulse, back to run.
    clearObs();
    applyStimulus(1'b0, 1, 2, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) idle();
    checkOutput("mul_busy_cycles", 32'(obsBusyProg), 32'd3);
    checkOutput("mul_start_pulses", 32'(obsMulStart), 32'd1);
    checkOutput("mul_end_state", 32'(state_o), 32'd0);

    // Memory wait: request held three cycles, ack in the third.
    clearObs();
    applyStimulus(1'b0, 1, 2, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1, 2, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1, 2, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mem_ack_release", 32'(lastOut), 32'd0);
    idle();
    checkOutput("mem_frozen_cycles", 32'(obsPcStall), 32'd2);
    checkOutput("mem_end_state", 32'(lastState), 32'd0);

    // Memory stall in the second busy cycle: resume without a second start.
    clearObs();
    applyStimulus(1'b0, 1, 2, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    applyStimulus(1'b0, 1, 2, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("resume_ack_out", 32'(lastOut), 32'(OUT_BUSY));
    repeat (4) idle();
    checkOutput("resume_busy_cycles", 32'(obsBusyProg), 32'd3);
    checkOutput("resume_start_pulses", 32'(obsMulStart), 32'd1);
    checkOutput("resume_end_state", 32'(state_o), 32'd0);

    // Branch under load-use is suppressed, then taken on the retry.
    applyStimulus(1'b0, 7, 0, 1'b1, 7, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("br_lu_flush", 32'(lastOut[4]), 32'd0);
    applyStimulus(1'b0, 7, 0, 1'b0, 7, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("br_retry_flush", 32'(lastOut[4]), 32'd1);

    // Branch flush together with a multiply issue.
    applyStimulus(1'b0, 1, 2, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("br_mul_flush", 32'(lastOut[4]), 32'd1);
    checkOutput("br_mul_state", 32'(state_o), 32'd1);

    // Reset mid-multiply.
    idle();
    applyStimulus(1'b1, 1, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_mid_out", 32'(lastOut), 32'd0);
    idle();
    checkOutput("rst_after_state", 32'(lastState), 32'd0);
    checkOutput("rst_after_count", 32'(lastCount), 32'd0);
    checkOutput("rst_after_out", 32'(lastOut), 32'd0);

    // Randomized traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 99) < 2,
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    $urandom_range(0, 99) < 30, int'($urandom_range(0, 7)),
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 50);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
